// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register selectors and status-register bit positions.
package cp0_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;
  localparam logic [4:0] CP0_MODE  = 5'd22;
  localparam logic [4:0] CP0_IPCLR = 5'd23;

  localparam int unsigned SR_IE  = 0;
  localparam int unsigned SR_EXL = 1;
  localparam int unsigned IM_LSB = 8;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: bit 0 is the highest priority.
module irq_prio_enc #(
  parameter int unsigned NUM_IRQ = 6
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [2:0]         idx
);

  // Scan from the top down so the lowest set index is the last one assigned.
  always_comb begin
    valid = 1'b0;
    idx   = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/cp0_irq_ctrl.sv
// CP0 interrupt controller: level/edge interrupt lines, masks, fixed priority,
// EPC capture, eret and mfc0/mtc0 access.
// Optional macro CP0_SYNC_EN inserts a 2-flop synchroniser ahead of the
// sampling flop (HWInt-to-IntReq latency 3 cycles instead of 1).
module cp0_irq_ctrl
  import cp0_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 6,
  parameter int unsigned PC_W    = 30,
  parameter logic [31:0] PRID    = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] HWInt,
  input  logic [PC_W-1:0]    ID_PCP1,
  input  logic               pipeline_stall,
  input  logic               cp0_we,
  input  logic [4:0]         cp0_sel,
  input  logic [31:0]        cp0_wdata,
  output logic [31:0]        cp0_rdata,
  input  logic               eret,
  output logic               IntReq,
  output logic [PC_W-1:0]    o_EPC
);

  logic [NUM_IRQ-1:0] hw_q, hw_d;
  logic [NUM_IRQ-1:0] im_q, im_n;
  logic               ie_q, ie_n, exl_q, exl_n;
  logic [PC_W-1:0]    epc_q, epc_n;
  logic [NUM_IRQ-1:0] mode_q, mode_n;
  logic [NUM_IRQ-1:0] edge_q, edge_n;
  logic [NUM_IRQ-1:0] rise, pend, masked;
  logic               enc_valid;
  logic [2:0]         enc_idx;
  logic               take;
  logic [NUM_IRQ-1:0] hw_in;

`ifdef CP0_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  // Two-flop synchroniser for asynchronous interrupt lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= HWInt;
      sync2_q <= sync1_q;
    end
  end

  assign hw_in = sync2_q;
`else
  assign hw_in = HWInt;
`endif

  // Sampling flop plus a delayed copy for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hw_q <= '0;
      hw_d <= '0;
    end else begin
      hw_q <= hw_in;
      hw_d <= hw_q;
    end
  end

  // A rising edge is visible as pending in the same cycle it is seen, so the
  // edge path has the same 1-cycle latency as the level path.
  assign rise   = hw_q & ~hw_d & mode_q;
  assign pend   = (mode_q & (edge_q | rise)) | (~mode_q & hw_q);
  assign masked = pend & im_q;
  assign IntReq = ie_q & ~exl_q & (|masked);
  assign take   = IntReq & ~pipeline_stall;
  assign o_EPC  = epc_q;

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio_enc (
    .req   (masked),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  // Next-state for architectural registers; take has the final say on EXL/EPC.
  always_comb begin
    im_n   = im_q;
    ie_n   = ie_q;
    exl_n  = exl_q;
    epc_n  = epc_q;
    mode_n = mode_q;
    edge_n = edge_q;
    if (cp0_we) begin
      unique case (cp0_sel)
        CP0_SR: begin
          im_n  = cp0_wdata[IM_LSB +: NUM_IRQ];
          ie_n  = cp0_wdata[SR_IE];
          exl_n = cp0_wdata[SR_EXL];
        end
        CP0_EPC:   epc_n  = cp0_wdata[PC_W+1:2];
        CP0_MODE:  mode_n = cp0_wdata[NUM_IRQ-1:0];
        CP0_IPCLR: edge_n = edge_q & ~cp0_wdata[NUM_IRQ-1:0];
        default: ;
      endcase
    end
    if (eret) exl_n = 1'b0;
    // Capture beats clear; channels now in level mode drop their latch.
    edge_n = (edge_n | rise) & mode_n;
    if (take) begin
      exl_n = 1'b1;
      epc_n = ID_PCP1;
    end
  end

  // Architectural state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_q   <= '0;
      ie_q   <= 1'b0;
      exl_q  <= 1'b0;
      epc_q  <= '0;
      mode_q <= '0;
      edge_q <= '0;
    end else begin
      im_q   <= im_n;
      ie_q   <= ie_n;
      exl_q  <= exl_n;
      epc_q  <= epc_n;
      mode_q <= mode_n;
      edge_q <= edge_n;
    end
  end

  // mfc0 read mux; unused bits read as zero.
  always_comb begin
    cp0_rdata = '0;
    unique case (cp0_sel)
      CP0_SR: begin
        cp0_rdata[IM_LSB +: NUM_IRQ] = im_q;
        cp0_rdata[SR_EXL]            = exl_q;
        cp0_rdata[SR_IE]             = ie_q;
      end
      CP0_CAUSE: begin
        cp0_rdata[IM_LSB +: NUM_IRQ] = pend;
        cp0_rdata[4:2]               = enc_valid ? enc_idx : 3'd0;
      end
      CP0_EPC:  cp0_rdata[PC_W+1:0] = {epc_q, 2'b00};
      CP0_PRID: cp0_rdata = PRID;
      CP0_MODE: cp0_rdata[NUM_IRQ-1:0] = mode_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Directed bench for cp0_irq_ctrl (NUM_IRQ=6, PC_W=30).
module tb_cp0_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  HWInt;
  logic [29:0] ID_PCP1;
  logic        pipeline_stall;
  logic        cp0_we;
  logic [4:0]  cp0_sel;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        eret;
  logic        IntReq;
  logic [29:0] o_EPC;

  int checks   = 0;
  int failures = 0;

  cp0_irq_ctrl #(
    .NUM_IRQ (6),
    .PC_W    (30),
    .PRID    (32'h0000_0100)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .HWInt          (HWInt),
    .ID_PCP1        (ID_PCP1),
    .pipeline_stall (pipeline_stall),
    .cp0_we         (cp0_we),
    .cp0_sel        (cp0_sel),
    .cp0_wdata      (cp0_wdata),
    .cp0_rdata      (cp0_rdata),
    .eret           (eret),
    .IntReq         (IntReq),
    .o_EPC          (o_EPC)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [4:0] sel, input logic [31:0] exp);
    cp0_sel = sel;
    #1;
    check(tag, cp0_rdata, exp);
  endtask

  task automatic mtc0(input logic [4:0] sel, input logic [31:0] data);
    cp0_we    = 1'b1;
    cp0_sel   = sel;
    cp0_wdata = data;
    tick();
    cp0_we    = 1'b0;
    cp0_wdata = '0;
  endtask

  int lat;

  initial begin
    rst = 1'b1; HWInt = '0; ID_PCP1 = '0; pipeline_stall = 1'b0;
    cp0_we = 1'b0; cp0_sel = '0; cp0_wdata = '0; eret = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Build up state, then reset mid-cycle.
    pipeline_stall = 1'b1;
    mtc0(5'd14, 32'h0000_1234);
    mtc0(5'd12, 32'h0000_0401);
    HWInt = 6'b000100;
    tick(); tick();
    check("pre_reset_intreq", {31'd0, IntReq}, 32'd1);
    rst = 1'b1;
    #1;
    check("reset_intreq", {31'd0, IntReq}, 32'd0);
    check("reset_epc", {2'b0, o_EPC}, 32'd0);
    check_reg("reset_sr", 5'd12, 32'd0);
    HWInt = '0;
    pipeline_stall = 1'b0;
    tick();
    rst = 1'b0;
    check_reg("reset_mode", 5'd22, 32'd0);
    check_reg("reset_cause", 5'd13, 32'd0);
    check_reg("prid", 5'd15, 32'h0000_0100);
    check_reg("unused_sel", 5'd3, 32'd0);

    // Level interrupt, take, eret.
    mtc0(5'd12, 32'h0000_0401);
    ID_PCP1 = 30'h0C00;
    HWInt = 6'b000100;
    check("level_before", {31'd0, IntReq}, 32'd0);
    tick();
    check("level_latency", {31'd0, IntReq}, 32'd1);
    tick();
    check_reg("take_epc", 5'd14, 32'h0000_3000);
    check("take_oepc", {2'b0, o_EPC}, 32'h0000_0C00);
    check_reg("take_sr_exl", 5'd12, 32'h0000_0403);
    check("take_intreq", {31'd0, IntReq}, 32'd0);
    eret = 1'b1;
    pipeline_stall = 1'b1;
    tick();
    eret = 1'b0;
    check_reg("eret_sr", 5'd12, 32'h0000_0401);
    check("eret_intreq", {31'd0, IntReq}, 32'd1);
    HWInt = '0;
    tick();
    check("level_drop", {31'd0, IntReq}, 32'd0);
    pipeline_stall = 1'b0;

    // Edge mode on line 0 (IE off so nothing is taken).
    mtc0(5'd22, 32'h0000_0001);
    mtc0(5'd12, 32'h0000_0100);
    HWInt = 6'b000001;
    tick();
    HWInt = '0;
    check_reg("edge_seen", 5'd13, 32'h0000_0100);
    tick(); tick();
    check_reg("edge_held", 5'd13, 32'h0000_0100);
    mtc0(5'd23, 32'h0000_0001);
    check_reg("edge_cleared", 5'd13, 32'h0000_0000);
    check_reg("ipclr_reads0", 5'd23, 32'd0);
    HWInt = 6'b000001;
    tick();
    HWInt = '0;
    mtc0(5'd23, 32'h0000_0001);
    check_reg("edge_capture_wins", 5'd13, 32'h0000_0100);
    mtc0(5'd23, 32'h0000_0001);
    check_reg("edge_clear_again", 5'd13, 32'h0000_0000);
    HWInt = 6'b000001;
    tick();
    HWInt = '0;
    tick();
    mtc0(5'd22, 32'h0000_0000);
    check_reg("mode_switch_drop", 5'd13, 32'h0000_0000);

    // Priority.
    HWInt = 6'b100100;
    mtc0(5'd12, 32'h0000_FF00);
    check_reg("prio_cause", 5'd13, 32'h0000_2408);
    check_reg("sr_im_trunc", 5'd12, 32'h0000_3F00);
    mtc0(5'd12, 32'h0000_FB00);
    check_reg("prio_masked", 5'd13, 32'h0000_2414);

    // Stall delays the take.
    pipeline_stall = 1'b1;
    mtc0(5'd12, 32'h0000_2001);
    for (int i = 0; i < 3; i++) begin
      ID_PCP1 = 30'h200 + 30'(i);
      check("stall_intreq", {31'd0, IntReq}, 32'd1);
      tick();
      check("stall_epc", {2'b0, o_EPC}, 32'h0000_0C00);
      check_reg("stall_sr", 5'd12, 32'h0000_2001);
    end
    pipeline_stall = 1'b0;
    ID_PCP1 = 30'h2AA;
    tick();
    check("stall_take_epc", {2'b0, o_EPC}, 32'h0000_02AA);
    check_reg("stall_take_sr", 5'd12, 32'h0000_2003);
    check("stall_take_intreq", {31'd0, IntReq}, 32'd0);

    // mtc0 SR in the take cycle.
    pipeline_stall = 1'b1;
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check("coll_intreq", {31'd0, IntReq}, 32'd1);
    pipeline_stall = 1'b0;
    ID_PCP1 = 30'h3CC;
    mtc0(5'd12, 32'h0000_FF00);
    check_reg("coll_sr", 5'd12, 32'h0000_3F02);
    check("coll_epc", {2'b0, o_EPC}, 32'h0000_03CC);
    check("coll_intreq_low", {31'd0, IntReq}, 32'd0);

    // HWInt-to-IntReq latency on line 1.
    pipeline_stall = 1'b1;
    HWInt = '0;
    eret = 1'b1;
    tick();
    eret = 1'b0;
    mtc0(5'd12, 32'h0000_0201);
    tick(); tick(); tick();
    check("lat_idle", {31'd0, IntReq}, 32'd0);
    HWInt = 6'b000010;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (IntReq && lat == 0) lat = i;
    end
`ifdef CP0_SYNC_EN
    check("irq_latency", lat, 32'd3);
`else
    check("irq_latency", lat, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cp0_irq_ctrl.md
Name: cp0_irq_ctrl

Overview:
Parametrised successor to the fixed 6-line CP0 of the 5-stage MIPS core. Handles NUM_IRQ hardware interrupt lines, each configurable as level- or edge-sensitive, with masks, fixed priority, EPC capture, eret, and mfc0/mtc0 access. Sits beside the ID stage. The Controller consumes IntReq to flush IF/ID/EX/MEM; ID uses o_EPC for eret.

Parameters:
NUM_IRQ, 6, number of hardware interrupt lines; legal range 1..8
PC_W, 30, width of word-address PC (bits 31:2)
PRID, 32'h0000_0100, constant returned by PRId read

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
HWInt  in  NUM_IRQ  raw interrupt lines; bit 0 has highest priority
ID_PCP1  in  PC_W  word address of the instruction currently in ID (return point)
pipeline_stall  in  1  hazard stall; an interrupt is never taken while it is high
cp0_we  in  1  mtc0 write strobe
cp0_sel  in  5  CP0 register number for mtc0/mfc0
cp0_wdata  in  32  mtc0 data
cp0_rdata  out  32  mfc0 data, combinational from cp0_sel
eret  in  1  eret executing in ID
IntReq  out  1  interrupt request to Controller
o_EPC  out  PC_W  current EPC value

Behaviour:
- Reset: SR, EPC, MODE, pending and sampled-input flops all 0, so IntReq=0 and o_EPC=0. Reset is asynchronous; it aborts any in-flight capture or clear.
- Input sampling: hw_q <= HWInt every cycle (1 flop). hw_d <= hw_q for edge detection.
- Registers (cp0_sel):
  - 12 SR: [15:8] IM (bits above NUM_IRQ read 0, writes ignored), [1] EXL, [0] IE. R/W.
  - 13 Cause: [15:8] IP = pending, read-only; [6:2] index of the highest-priority masked pending line (0 if none).
  - 14 EPC: {EPC, 2'b00}. Writable.
  - 15 PRId: reads PRID.
  - 22 MODE: [NUM_IRQ-1:0], 1 = edge-sensitive. R/W.
  - 23 IPCLR: write-1-to-clear of edge-pending bits; reads 0.
  - Any other selector reads 0; writes to it are ignored.
- Pending:
  - Level channel: pend[i] = hw_q[i].
  - Edge channel: pend[i] sets on hw_q & ~hw_d, holds until cleared via IPCLR.
  - Capture and clear in the same cycle: capture wins.
  - Switching a channel from edge to level via MODE drops its latched bit.
- IntReq = IE & ~EXL & |(pend & IM). Combinational from flops only; no input-to-output path.
- Take: fires when IntReq & ~pipeline_stall. At that edge: EPC <= ID_PCP1 and EXL <= 1. IntReq is therefore low from the next cycle. Latency from an HWInt edge to IntReq is 1 cycle.
- eret: EXL <= 0 at the edge. o_EPC remains valid throughout.
- Simultaneous events:
  - Take and mtc0 SR: mtc0 data is written to IM/IE, then EXL is forced to 1.
  - Take and mtc0 EPC: take wins.
  - Take and eret: unreachable, because eret implies EXL=1. If both occur anyway, take wins.
  - mtc0 SR and eret: eret clears EXL; mtc0 sets IM/IE.
- A stall holding for N cycles delays the take by N cycles. Pending state is kept throughout.

Optional Feature:
CP0_SYNC_EN
- Defined: a 2-flop synchroniser precedes hw_q. HWInt-to-IntReq latency becomes 3 cycles; edge detection runs on the synchronised signal.
- Undefined: single sampling flop only; latency is 1 cycle.

Decomposition:
- Shared package cp0_pkg:
  - Selector constants CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15, CP0_MODE=22, CP0_IPCLR=23.
  - Bit positions SR_IE=0, SR_EXL=1, IM_LSB=8.
- One sub-module, irq_prio_enc: NUM_IRQ-wide lowest-index-first priority encoder producing a valid bit and a 3-bit index. Used for Cause[6:2].

Test Plan:
- Reset and level IRQ:
  - Stimulus: assert rst mid-run; release; mtc0 SR=32'h0000_0401 (IM[2], IE); raise HWInt[2] as a level with ID_PCP1=30'h0C00.
  - Response: IntReq=1 one cycle later. Take occurs; EPC reads 32'h0000_3000; EXL=1; IntReq=0. eret clears EXL; IntReq returns to 1 while HWInt[2] stays high.
- Edge mode:
  - Stimulus: MODE=6'b000001; pulse HWInt[0] for 1 cycle.
  - Response: Cause IP[8]=1 persists after the pulse. A write of 1 to IPCLR clears it. A pulse arriving in the same cycle as the clear leaves IP[8]=1.
- Priority:
  - Stimulus: HWInt=6'b100100 with IM all ones.
  - Response: Cause[6:2]=2. Masking IM[2] gives Cause[6:2]=5.
- Stall:
  - Stimulus: hold pipeline_stall=1 for 3 cycles with IntReq=1.
  - Response: EPC and EXL are unchanged during the stall. The take happens in the first unstalled cycle, capturing that cycle's ID_PCP1.
- Collision:
  - Stimulus: mtc0 SR=32'h0000_FF00 in the take cycle.
  - Response: SR reads 32'h0000_3F02 for NUM_IRQ=6, with EXL set and IE=0.
- CP0_SYNC_EN:
  - Stimulus: build with the macro defined; raise HWInt[1] with IM[1] and IE set.
  - Response: IntReq rises exactly 3 cycles after the HWInt[1] edge.
